// File: rtl/instruction_queue_pkg.sv
// instruction_queue_pkg: shared cpu constants for MIPS field positions and the nop encoding.
package instruction_queue_pkg;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB = 0;
endpackage

// File: rtl/instruction_queue_if.sv
// instruction_queue_if: fetch-side push/pop/flush controls and head/status/field outputs.
interface instruction_queue_if #(parameter int DEPTH = 4);
  logic [31:0] MemData;
  logic IRWrite;
  logic IRAdvance;
  logic Flush;
  logic [31:0] Instruction;
  logic Valid;
  logic Full;
  logic Empty;
  logic [$clog2(DEPTH):0] Count;
  logic Overflow;
  logic [5:0] Opcode;
  logic [4:0] Rs;
  logic [4:0] Rt;
  logic [4:0] Rd;
  logic [4:0] Shamt;
  logic [5:0] Funct;
  logic [15:0] Imm16;
  modport master (
    output MemData, IRWrite, IRAdvance, Flush,
    input Instruction, Valid, Full, Empty, Count, Overflow, Opcode, Rs, Rt, Rd, Shamt, Funct, Imm16
  );
  modport slave (
    input MemData, IRWrite, IRAdvance, Flush,
    output Instruction, Valid, Full, Empty, Count, Overflow, Opcode, Rs, Rt, Rd, Shamt, Funct, Imm16
  );
endinterface

// File: rtl/instruction_queue_instr_fields.sv
// instr_fields: combinational MIPS field slicing, shared with decode.
module instr_fields
  import instruction_queue_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);
  assign opcode = instr[OPCODE_LSB +: 6];
  assign rs     = instr[RS_LSB +: 5];
  assign rt     = instr[RT_LSB +: 5];
  assign rd     = instr[RD_LSB +: 5];
  assign shamt  = instr[SHAMT_LSB +: 5];
  assign funct  = instr[FUNCT_LSB +: 6];
  assign imm16  = instr[IMM_LSB +: 16];
endmodule

// File: rtl/instruction_queue.sv
// instruction_queue: circular instruction buffer with combinational head read and sticky overflow.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_INSTR = NOP
) (
  input logic clk,
  input logic rst,
  instruction_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic ovf, full, empty, push, pop, reject;
  assign full   = count == (AW+1)'(DEPTH);
  assign empty  = count == '0;
  // When full, a same-edge pop frees the slot the push writes into.
  assign push   = q.IRWrite && (!full || q.IRAdvance);
  assign pop    = q.IRAdvance && !empty;
  assign reject = q.IRWrite && full && !q.IRAdvance;
  always_ff @(posedge clk) begin
    if (rst || q.Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (reject) ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push && !rst && !q.Flush) mem[wr_ptr] <= q.MemData;
  assign q.Instruction = empty ? RESET_INSTR : mem[rd_ptr];
  assign q.Valid       = !empty;
  assign q.Full        = full;
  assign q.Empty       = empty;
  assign q.Count       = count;
  assign q.Overflow    = ovf;
  instr_fields u_fields (
    .instr  (q.Instruction),
    .opcode (q.Opcode),
    .rs     (q.Rs),
    .rt     (q.Rt),
    .rd     (q.Rd),
    .shamt  (q.Shamt),
    .funct  (q.Funct),
    .imm16  (q.Imm16)
  );
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: table-driven directed vectors plus hand-written field and corner checks.
module tb_instruction_queue;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  instruction_queue_if #(.DEPTH(4)) q ();
  instruction_queue #(.DEPTH(4), .RESET_INSTR(32'h0000_0000)) dut (.clk(clk), .rst(rst), .q(q));
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [31:0] d;
    logic        wr;
    logic        adv;
    logic        fl;
    int          cnt;
    logic [31:0] ins;
    logic        ovf;
  } vec_t;
  vec_t v[$];

  task automatic add(input logic r, input logic [31:0] d, input logic wr, input logic adv,
                     input logic fl, input int cnt, input logic [31:0] ins, input logic ovf);
    v.push_back('{r, d, wr, adv, fl, cnt, ins, ovf});
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] d, input logic wr, input logic adv, input logic fl);
    @(negedge clk);
    rst = r; q.MemData = d; q.IRWrite = wr; q.IRAdvance = adv; q.Flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; q.MemData = '0; q.IRWrite = 1'b0; q.IRAdvance = 1'b0; q.Flush = 1'b0;
    // reset, then three pushes with no pop; fields checked by hand below
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset_count", -1, 32'(q.Count), 32'd0);
    chk("reset_empty", -1, 32'(q.Empty), 32'd1);
    chk("reset_valid", -1, 32'(q.Valid), 32'd0);
    chk("reset_instr", -1, q.Instruction, 32'h0);
    step(1'b0, 32'h8C220004, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h00221820, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h1000FFFF, 1'b1, 1'b0, 1'b0);
    chk("lw_count", -1, 32'(q.Count), 32'd3);
    chk("lw_instr", -1, q.Instruction, 32'h8C220004);
    chk("lw_opcode", -1, 32'(q.Opcode), 32'h23);
    chk("lw_rs", -1, 32'(q.Rs), 32'd1);
    chk("lw_rt", -1, 32'(q.Rt), 32'd2);
    chk("lw_imm16", -1, 32'(q.Imm16), 32'h0004);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("add_rd", -1, 32'(q.Rd), 32'd3);
    chk("add_funct", -1, 32'(q.Funct), 32'h20);
    chk("add_shamt", -1, 32'(q.Shamt), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("beq_imm16", -1, 32'(q.Imm16), 32'hFFFF);
    chk("beq_opcode", -1, 32'(q.Opcode), 32'h04);

    // table: state after each edge; queue currently holds one word (1000FFFF)
    add(1, 32'h0,        0, 0, 0, 0, 32'h0,        0);
    add(0, 32'h8C220004, 1, 0, 0, 1, 32'h8C220004, 0);
    add(0, 32'h00221820, 1, 0, 0, 2, 32'h8C220004, 0);
    add(0, 32'h1000FFFF, 1, 0, 0, 3, 32'h8C220004, 0);
    add(0, 32'h11111111, 1, 0, 0, 4, 32'h8C220004, 0);
    add(0, 32'h22222222, 1, 0, 0, 4, 32'h8C220004, 1);
    add(0, 32'h0,        0, 1, 0, 3, 32'h00221820, 1);
    add(0, 32'h0,        0, 1, 0, 2, 32'h1000FFFF, 1);
    add(0, 32'h33333333, 1, 1, 1, 0, 32'h0,        0);
    add(0, 32'h0,        0, 1, 0, 0, 32'h0,        0);
    add(0, 32'h20080005, 1, 1, 0, 1, 32'h20080005, 0);
    add(0, 32'h0,        0, 0, 1, 0, 32'h0,        0);
    add(0, 32'hA0000001, 1, 0, 0, 1, 32'hA0000001, 0);
    add(0, 32'hA0000002, 1, 0, 0, 2, 32'hA0000001, 0);
    add(0, 32'hA0000003, 1, 0, 0, 3, 32'hA0000001, 0);
    add(0, 32'hA0000004, 1, 0, 0, 4, 32'hA0000001, 0);
    add(0, 32'hB0000001, 1, 1, 0, 4, 32'hA0000002, 0);
    add(0, 32'hB0000002, 1, 1, 0, 4, 32'hA0000003, 0);
    add(0, 32'hB0000003, 1, 1, 0, 4, 32'hA0000004, 0);
    add(0, 32'hB0000004, 1, 1, 0, 4, 32'hB0000001, 0);
    add(0, 32'hB0000005, 1, 1, 0, 4, 32'hB0000002, 0);
    add(0, 32'hB0000006, 1, 1, 0, 4, 32'hB0000003, 0);
    add(0, 32'hB0000007, 1, 1, 0, 4, 32'hB0000004, 0);
    add(0, 32'hB0000008, 1, 1, 0, 4, 32'hB0000005, 0);
    add(0, 32'hCCCCCCCC, 1, 0, 0, 4, 32'hB0000005, 1);
    add(0, 32'h0,        0, 1, 0, 3, 32'hB0000006, 1);
    add(1, 32'hDDDDDDDD, 1, 1, 1, 0, 32'h0,        0);
    add(0, 32'hEEEEEEEE, 1, 0, 0, 1, 32'hEEEEEEEE, 0);
    add(0, 32'h0,        0, 1, 0, 0, 32'h0,        0);

    for (int i = 0; i < v.size(); i++) begin
      step(v[i].r, v[i].d, v[i].wr, v[i].adv, v[i].fl);
      chk("count", i, 32'(q.Count), 32'(v[i].cnt));
      chk("instr", i, q.Instruction, v[i].ins);
      chk("overflow", i, 32'(q.Overflow), 32'(v[i].ovf));
      chk("full", i, 32'(q.Full), 32'(v[i].cnt == 4));
      chk("empty", i, 32'(q.Empty), 32'(v[i].cnt == 0));
      chk("valid", i, 32'(q.Valid), 32'(v[i].cnt != 0));
      chk("opcode", i, 32'(q.Opcode), 32'(v[i].ins[31:26]));
      chk("imm16", i, 32'(q.Imm16), 32'(v[i].ins[15:0]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries; SHALL be one of 2, 4, 8 or 16.
REQ-002 Parameter RESET_INSTR, default 32'h0000_0000 (nop), value driven on Instruction while the queue is empty.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 MemData  input  32  instruction word from memory.
REQ-006 IRWrite  input  1  push request; MemData is enqueued when accepted.
REQ-007 IRAdvance  input  1  pop request; retires the head entry.
REQ-008 Flush  input  1  discard all entries (branch/jump redirect).
REQ-009 Instruction  output  32  head entry, or RESET_INSTR when empty.
REQ-010 Valid  output  1  head entry present (= !Empty).
REQ-011 Full, Empty  output  1 each  occupancy flags.
REQ-012 Count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-013 Overflow  output  1  sticky flag: a push was rejected.
REQ-014 Opcode[5:0], Rs[4:0], Rt[4:0], Rd[4:0], Shamt[4:0], Funct[5:0], Imm16[15:0]  outputs  MIPS fields sliced from Instruction: bits 31:26, 25:21, 20:16, 15:11, 10:6, 5:0 and 15:0.

Function
REQ-015 Storage SHALL be a DEPTH-entry circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 Push acceptance: accepted when IRWrite && (!Full || IRAdvance); write lands at write pointer on the same edge; the entry is visible on Instruction the next cycle if it is the head.
REQ-017 Pop acceptance: accepted when IRAdvance && !Empty; pop on empty has no effect.
REQ-018 Push+pop on the same edge with 0<Count<DEPTH: both take effect, Count unchanged.
REQ-019 Push+pop when Full: both take effect, Count stays DEPTH, Overflow not set.
REQ-020 Push+pop when Empty: push only, Count becomes 1.
REQ-021 Rejected push (IRWrite && Full && !IRAdvance): storage unchanged, Overflow set to 1 on that edge.
REQ-022 Flush: pointers and Count go to 0 on that edge; overrides IRWrite and IRAdvance in the same cycle; clears Overflow; storage contents not cleared.
REQ-023 Instruction SHALL be a combinational read of the head entry (no extra latency beyond the storage register); holds its value while no pop occurs, matching the hold behaviour of an IRWrite-gated register.
REQ-024 Full = (Count==DEPTH), Empty = (Count==0), both derived from Count.
REQ-025 Field outputs SHALL be pure slices of Instruction, so they equal RESET_INSTR slices when empty.

Reset
REQ-026 On rst, pointers, Count and Overflow SHALL go to 0; Empty=1, Valid=0, Full=0; Instruction=RESET_INSTR; storage not reset.
REQ-027 rst SHALL override Flush, IRWrite and IRAdvance in the same cycle; reset mid-burst discards all entries.

Structure
REQ-028 The shared cpu package SHALL hold the MIPS field bit-position constants and the nop encoding used by RESET_INSTR.
REQ-029 One sub-module, instr_fields, SHALL perform the field slicing (combinational, reusable by decode).
REQ-030 The storage array SHALL have no reset, so it can map to distributed RAM.

Verification
REQ-031 After rst, push 0x8C220004, 0x00221820, 0x1000FFFF with no pop -> Count=3; Instruction=0x8C220004; Opcode=6'h23, Rs=1, Rt=2, Imm16=16'h0004.
REQ-032 DEPTH=4: push 5 words with no pop -> Full=1 after the 4th; 5th rejected; Overflow=1; head unchanged; Count=4.
REQ-033 Full, then push+pop every cycle for 8 cycles -> Count stays 4, Overflow stays 0, words retire in order across pointer wrap.
REQ-034 Count=2 and Flush asserted with IRWrite=1 -> next cycle Count=0, Empty=1, Instruction=RESET_INSTR, pushed word discarded.
REQ-035 Empty and IRWrite+IRAdvance together with MemData=0x20080005 -> next cycle Count=1, Instruction=0x20080005.
REQ-036 rst asserted while Count=3 and pushing -> next cycle Count=0, Overflow=0, Instruction=RESET_INSTR.
